// File: rtl/log_arbiter.sv
// log_arbiter: round-robin arbiter that funnels NUM_REQ severity-tagged messages onto one log channel.
// Optional macro LOG_ARB_DISPLAY_EN prints every delivered message (and raises $error on FATAL) in simulation.
module log_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*2-1:0]      req_sev,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      log_valid,
  input  logic                      log_ready,
  output logic [DATA_W-1:0]         log_data,
  output logic [SRC_W-1:0]          log_src,
  output logic [1:0]                log_sev,
  output logic [15:0]               msg_count,
  output logic [7:0]                err_count,
  output logic                      halted
);

  localparam logic [1:0] SEV_ERROR = 2'd2;
  localparam logic [1:0] SEV_FATAL = 2'd3;

  typedef enum logic [1:0] {IDLE, SEND, HALT} state_e;

  state_e              state_q;
  logic [SRC_W-1:0]    last_grant_q;
  logic                log_valid_q;
  logic [DATA_W-1:0]   log_data_q;
  logic [SRC_W-1:0]    log_src_q;
  logic [1:0]          log_sev_q;
  logic [15:0]         msg_count_q;
  logic [15:0]         msg_count_d;
  logic [7:0]          err_count_q;
  logic [7:0]          err_count_d;
  logic                halted_q;

  logic [DATA_W-1:0]   data_arr [NUM_REQ];
  logic [1:0]          sev_arr  [NUM_REQ];
  logic [SRC_W-1:0]    cand;
  logic                grant_found;
  logic [SRC_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0]  grant_oh;
  logic                handshake;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    assign sev_arr[g]  = req_sev[g*2 +: 2];
  end

  // Walk the requesters starting one past the last winner so every source gets a fair turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_oh    = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = SRC_W'((int'(last_grant_q) + 1 + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found    = 1'b1;
        grant_idx      = cand;
        grant_oh[cand] = 1'b1;
      end
    end
  end

  assign req_ready = (state_q == IDLE && grant_found && !rst) ? grant_oh : '0;
  assign handshake = (state_q == SEND) && log_ready;

  assign msg_count_d = msg_count_q + 16'd1;
  assign err_count_d = (log_sev_q == SEV_ERROR && err_count_q != 8'hFF) ? err_count_q + 8'd1
                                                                          : err_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= SRC_W'(NUM_REQ - 1);
      log_valid_q  <= 1'b0;
      log_data_q   <= '0;
      log_src_q    <= '0;
      log_sev_q    <= '0;
      msg_count_q  <= '0;
      err_count_q  <= '0;
      halted_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            log_data_q   <= data_arr[grant_idx];
            log_sev_q    <= sev_arr[grant_idx];
            log_src_q    <= grant_idx;
            last_grant_q <= grant_idx;
            log_valid_q  <= 1'b1;
            state_q      <= SEND;
          end
        end
        SEND: begin
          if (log_ready) begin
            msg_count_q <= msg_count_d;
            err_count_q <= err_count_d;
            log_valid_q <= 1'b0;
            if (log_sev_q == SEV_FATAL) begin
              halted_q <= 1'b1;
              state_q  <= HALT;
            end else begin
              state_q  <= IDLE;
            end
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign log_valid = log_valid_q;
  assign log_data  = log_data_q;
  assign log_src   = log_src_q;
  assign log_sev   = log_sev_q;
  assign msg_count = msg_count_q;
  assign err_count = err_count_q;
  assign halted    = halted_q;

`ifdef LOG_ARB_DISPLAY_EN
  function automatic string sev_name(input logic [1:0] s);
    case (s)
      2'd0:    return "INFO";
      2'd1:    return "WARNING";
      2'd2:    return "ERROR";
      default: return "FATAL";
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst && handshake) begin
      $display("[%0t] src=%0d sev=%s data=%h", $time, log_src_q, sev_name(log_sev_q), log_data_q);
      if (log_sev_q == SEV_FATAL)
        $error("log_arbiter: FATAL message from src=%0d", log_src_q);
    end
  end
`else
  // Silent build: the handshake strobe exists only to feed the message printer.
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_log_arbiter.sv
// tb_log_arbiter: table vectors, directed corner sequences and randomized traffic against
// a transaction-level reference model of the round-robin log arbiter.
module tb_log_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  reqValid;
  logic [N*DW-1:0] reqData;
  logic [N*2-1:0]  reqSev;
  logic          logReady;
  logic [N-1:0]  reqReady;
  logic          logValid;
  logic [DW-1:0] logData;
  logic [1:0]    logSrc;
  logic [1:0]    logSev;
  logic [15:0]   msgCount;
  logic [7:0]    errCount;
  logic          halted;

  log_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (reqValid),
    .req_data  (reqData),
    .req_sev   (reqSev),
    .req_ready (reqReady),
    .log_valid (logValid),
    .log_ready (logReady),
    .log_data  (logData),
    .log_src   (logSrc),
    .log_sev   (logSev),
    .msg_count (msgCount),
    .err_count (errCount),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  int vectorCount = 0;
  int missCount   = 0;

  // Reference model: one message "in flight" or none, plus delivery statistics.
  bit       mBusy, mHalted;
  int       mLast, mData, mSrc, mSev, mMsg, mErr, mGrant;
  logic [N-1:0] expReady;

  typedef struct {
    logic [N-1:0] valid;
    logic         ready;
    logic [N-1:0] expReady;
    logic         expLogValid;
    logic [1:0]   expSrc;
    logic [15:0]  expMsg;
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectorCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                               input logic [N*2-1:0] s, input logic r);
    reqValid = v;
    reqData  = d;
    reqSev   = s;
    logReady = r;
  endtask

  task automatic modelReset();
    mBusy = 0; mHalted = 0; mLast = N - 1;
    mData = 0; mSrc = 0; mSev = 0; mMsg = 0; mErr = 0;
  endtask

  task automatic modelOutputs();
    expReady = '0;
    mGrant   = -1;
    if (!mBusy && !mHalted) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (mLast + 1 + k) % N;
        if (mGrant < 0 && reqValid[j]) begin
          mGrant      = j;
          expReady[j] = 1'b1;
        end
      end
    end
  endtask

  task automatic modelEdge();
    if (mGrant >= 0) begin
      mBusy = 1;
      mLast = mGrant;
      mSrc  = mGrant;
      mData = int'(reqData[mGrant*DW +: DW]);
      mSev  = int'(reqSev[mGrant*2 +: 2]);
    end else if (mBusy && logReady) begin
      mMsg  = (mMsg + 1) % 65536;
      if (mSev == 2 && mErr < 255) mErr++;
      mBusy = 0;
      if (mSev == 3) mHalted = 1;
    end
  endtask

  task automatic checkModel();
    checkOutput("req_ready", 32'(reqReady), 32'(expReady));
    checkOutput("log_valid", 32'(logValid), 32'(mBusy));
    checkOutput("log_data",  32'(logData),  32'(mData));
    checkOutput("log_src",   32'(logSrc),   32'(mSrc));
    checkOutput("log_sev",   32'(logSev),   32'(mSev));
    checkOutput("msg_count", 32'(msgCount), 32'(mMsg));
    checkOutput("err_count", 32'(errCount), 32'(mErr));
    checkOutput("halted",    32'(halted),   32'(mHalted));
  endtask

  task automatic stepCycle();
    @(negedge clk);
    modelOutputs();
    checkModel();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("rst_req_ready", 32'(reqReady), 32'h0);
    checkOutput("rst_log_valid", 32'(logValid), 32'h0);
    checkOutput("rst_log_data",  32'(logData),  32'h0);
    checkOutput("rst_log_src",   32'(logSrc),   32'h0);
    checkOutput("rst_msg_count", 32'(msgCount), 32'h0);
    checkOutput("rst_err_count", 32'(errCount), 32'h0);
    checkOutput("rst_halted",    32'(halted),   32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0]   pendV;
    logic [DW-1:0]  pendD [N];
    logic [1:0]     pendS [N];
    logic [N*DW-1:0] d;
    logic [N*2-1:0]  s;
    int haltCycles;

    rst = 1'b1;
    applyStimulus('0, '0, '0, 1'b0);

    // All four requesters always pending: grants rotate 0,1,2,3,0 two cycles apart.
    vecs[0] = '{4'hF, 1'b1, 4'b0001, 1'b0, 2'd0, 16'd0};
    vecs[1] = '{4'hF, 1'b1, 4'b0000, 1'b1, 2'd0, 16'd0};
    vecs[2] = '{4'hF, 1'b1, 4'b0010, 1'b0, 2'd0, 16'd1};
    vecs[3] = '{4'hF, 1'b1, 4'b0000, 1'b1, 2'd1, 16'd1};
    vecs[4] = '{4'hF, 1'b1, 4'b0100, 1'b0, 2'd1, 16'd2};
    vecs[5] = '{4'hF, 1'b1, 4'b0000, 1'b1, 2'd2, 16'd2};
    vecs[6] = '{4'hF, 1'b1, 4'b1000, 1'b0, 2'd2, 16'd3};
    vecs[7] = '{4'hF, 1'b1, 4'b0000, 1'b1, 2'd3, 16'd3};
    vecs[8] = '{4'hF, 1'b1, 4'b0001, 1'b0, 2'd3, 16'd4};

    doReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].valid, 32'h44332211, 8'h00, vecs[i].ready);
      @(negedge clk);
      checkOutput($sformatf("tbl%0d_req_ready", i), 32'(reqReady), 32'(vecs[i].expReady));
      checkOutput($sformatf("tbl%0d_log_valid", i), 32'(logValid), 32'(vecs[i].expLogValid));
      checkOutput($sformatf("tbl%0d_log_src", i),   32'(logSrc),   32'(vecs[i].expSrc));
      checkOutput($sformatf("tbl%0d_msg_count", i), 32'(msgCount), 32'(vecs[i].expMsg));
      modelOutputs();
      @(posedge clk);
      modelEdge();
      #1;
    end

    // Requester 2 sends an ERROR while the sink stalls for five cycles.
    doReset();
    applyStimulus(4'b0100, 32'h00A50000, 8'b0010_0000, 1'b0);
    stepCycle();
    reqValid = '0;
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkOutput("stall_log_valid", 32'(logValid), 32'h1);
      checkOutput("stall_log_data",  32'(logData),  32'hA5);
      checkOutput("stall_log_src",   32'(logSrc),   32'h2);
      checkOutput("stall_err_count", 32'(errCount), 32'h0);
    end
    logReady = 1'b1;
    stepCycle();
    checkOutput("stall_err_after", 32'(errCount), 32'h1);
    checkOutput("stall_valid_after", 32'(logValid), 32'h0);

    // FATAL from requester 1 freezes the arbiter until reset.
    doReset();
    applyStimulus(4'b1010, 32'h33221100, 8'b0000_1100, 1'b1);
    stepCycle();
    stepCycle();
    checkOutput("fatal_halted", 32'(halted), 32'h1);
    checkOutput("fatal_msg_count", 32'(msgCount), 32'h1);
    for (int i = 0; i < 20; i++) begin
      stepCycle();
      checkOutput("halt_req_ready", 32'(reqReady), 32'h0);
      checkOutput("halt_msg_count", 32'(msgCount), 32'h1);
    end
    reqValid = 4'b1001;
    doReset();
    checkOutput("post_halt_cleared", 32'(halted), 32'h0);
    stepCycle();
    checkOutput("post_halt_grant_src", 32'(logSrc), 32'h0);

    // 257 ERROR deliveries: err_count saturates at 255 while msg_count keeps going.
    doReset();
    applyStimulus(4'b0001, 32'h000000E7, 8'b0000_0010, 1'b1);
    for (int i = 0; i < 512; i++) stepCycle();
    checkOutput("sat_err_count", 32'(errCount), 32'd255);
    checkOutput("sat_msg_count", 32'(msgCount), 32'd256);
    stepCycle();
    stepCycle();
    checkOutput("sat_err_hold", 32'(errCount), 32'd255);
    checkOutput("sat_msg_next", 32'(msgCount), 32'd257);

    // Asynchronous reset in the middle of a SEND cycle drops the message.
    doReset();
    applyStimulus(4'b0010, 32'h0000BE00, 8'h00, 1'b0);
    stepCycle();
    checkOutput("mid_in_send", 32'(logValid), 32'h1);
    reqValid = 4'b0011;
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("mid_log_valid", 32'(logValid), 32'h0);
    checkOutput("mid_req_ready", 32'(reqReady), 32'h0);
    checkOutput("mid_msg_count", 32'(msgCount), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    stepCycle();
    checkOutput("mid_first_grant", 32'(logSrc), 32'h0);

    // Randomized traffic: requesters hold each message until it is accepted.
    doReset();
    pendV = '0;
    haltCycles = 0;
    for (int i = 0; i < N; i++) begin
      pendD[i] = '0;
      pendS[i] = '0;
    end
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pendV[i] && $urandom_range(0, 2) == 0) begin
          pendV[i] = 1'b1;
          pendD[i] = DW'($urandom);
          pendS[i] = ($urandom_range(0, 40) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        end
        d[i*DW +: DW] = pendD[i];
        s[i*2 +: 2]   = pendS[i];
      end
      applyStimulus(pendV, d, s, $urandom_range(0, 3) != 0);
      stepCycle();
      pendV = pendV & ~expReady;
      haltCycles = mHalted ? haltCycles + 1 : 0;
      if (haltCycles > 5) begin
        doReset();
        haltCycles = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
